// File: rtl/sort_pkg.sv
// sort_pkg: shared FSM encoding and constants for the sort result checker
package sort_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, ISSUE, CAPT, DONE} state_t;
  localparam int ELEM_BYTES = 8;
  localparam logic [7:0] NO_BAD_IDX = 8'hFF;
endpackage

// File: rtl/halt_detector.sv
// halt_detector: counts consecutive pc_out==HALT_PC cycles (clk, reset, pc_out in; match, one-cycle halted pulse out)
module halt_detector #(
  parameter logic [63:0] HALT_PC = 64'h60,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_out,
  output logic        match,
  output logic        halted
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign match = pc_out == HALT_PC;
  assign halted = match && cnt == CW'(SETTLE_CYCLES - 1);
  always_ff @(posedge clk)
    cnt <= reset || !match ? '0 : halted || cnt == CW'(SETTLE_CYCLES) ? CW'(SETTLE_CYCLES) : cnt + 1'b1;
endmodule

// File: rtl/sort_result_checker.sv
// sort_result_checker: after halt, reads the array back via rd_en/rd_addr/rd_data and reports busy/done/pass/inv_count/first_bad/min_val/max_val
module sort_result_checker
  import sort_pkg::*;
#(
  parameter int N_ELEMS = 6,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [63:0] HALT_PC = 64'h60,
  parameter int SETTLE_CYCLES = 4,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       pc_out,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        inv_count,
  output logic [7:0]        first_bad,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val
);
  state_t state, nxt;
  logic match, halted, last, lt;
  logic [7:0] idx;
  logic [DATA_W-1:0] prev;
  halt_detector #(.HALT_PC(HALT_PC), .SETTLE_CYCLES(SETTLE_CYCLES)) u_halt (
    .clk(clk), .reset(reset), .pc_out(pc_out), .match(match), .halted(halted)
  );
  assign last = idx == 8'(N_ELEMS - 1);
  assign lt = SIGNED_CMP ? $signed(rd_data) < $signed(prev) : rd_data < prev;
  assign rd_en = state == ISSUE;
  assign busy = state == ISSUE || state == CAPT;
  assign done = state == DONE;
  assign pass = done && inv_count == 8'd0;
  always_comb begin
    nxt = state;
    nxt = state == IDLE || state == SETTLE ? (halted ? ISSUE : match ? SETTLE : IDLE) :
          state == ISSUE ? CAPT :
          state == CAPT ? (last ? DONE : ISSUE) : DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      rd_addr <= '0;
      prev <= '0;
      inv_count <= '0;
      first_bad <= NO_BAD_IDX;
      min_val <= '0;
      max_val <= '0;
    end else begin
      state <= nxt;
      if ((state == IDLE || state == SETTLE) && halted) rd_addr <= BASE_ADDR;
      if (state == CAPT) begin
        prev <= rd_data;
        if (idx != 8'd0 && lt) begin
          inv_count <= inv_count == 8'hFF ? inv_count : inv_count + 1'b1;
          if (first_bad == NO_BAD_IDX) first_bad <= idx;
        end
        if (idx == 8'd0) min_val <= rd_data;
        if (last) max_val <= rd_data;
        if (!last) begin
          idx <= idx + 1'b1;
          rd_addr <= rd_addr + ADDR_W'(ELEM_BYTES);
        end
      end
    end
  end
endmodule
